// File: rtl/pc_interface_pkg.sv
// pc_interface_pkg: constants, FSM state encoding and error codes shared by
// the PC-interface stages.
package pc_interface_pkg;

  localparam logic [7:0] PC_IF_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    PC_IF_IDLE = 2'd0,
    PC_IF_ADDR = 2'd1,
    PC_IF_DATA = 2'd2,
    PC_IF_CHK  = 2'd3
  } pc_if_state_e;

  localparam logic [1:0] PC_IF_ERR_ADDR    = 2'b01;
  localparam logic [1:0] PC_IF_ERR_CHK     = 2'b10;
  localparam logic [1:0] PC_IF_ERR_TIMEOUT = 2'b11;

  // True when the upper address-byte bits beyond the register space are clear.
  function automatic logic pc_if_addr_ok(input logic [7:0] b, input int unsigned aw);
    return (b >> aw) == 8'd0;
  endfunction

endpackage

// File: rtl/pc_interface_timeout.sv
// pc_interface_timeout: clearable, enable-gated idle counter. o_tc pulses
// combinationally in the cycle whose clock edge would bring the count to MAX;
// the counter wraps to zero on that edge. Clear has priority over counting.
module pc_interface_timeout #(
  parameter int unsigned MAX = 100000
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;
  logic          at_end;

  assign at_end = (cnt_q == CW'(MAX - 1));
  assign o_tc   = i_en && !i_clr && at_end;

  // Count idle cycles while enabled; any clear restarts from zero.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)   cnt_q <= '0;
    else if (i_clr)  cnt_q <= '0;
    else if (i_en)   cnt_q <= at_end ? '0 : cnt_q + CW'(1);
  end

endmodule

// File: rtl/pc_interface_cmd_decoder.sv
// pc_interface_cmd_decoder: assembles framed write commands from the UART
// byte stream (A5, addr, data MSB first, optional XOR checksum) and issues a
// one-cycle write strobe. Malformed or stalled frames pulse o_err.
// Optional feature macro: PC_INTERFACE_CHECKSUM_EN (adds the checksum byte).
module pc_interface_cmd_decoder
  import pc_interface_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_wr,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_err,
  output logic [1:0]            o_err_code
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  pc_if_state_e          state_q;
  logic [ADDR_WIDTH-1:0] addr_sh_q;
  logic [DATA_WIDTH-1:0] data_sh_q;
  logic [DATA_WIDTH-1:0] data_sh_d;
  logic [BCW-1:0]        byte_cnt_q;
  logic                  last_byte;
  logic                  wr_q, err_q;
  logic [1:0]            code_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  tmo_tc;
`ifdef PC_INTERFACE_CHECKSUM_EN
  logic [7:0]            chk_q;
`endif

  // Shift the incoming byte into the low end; the oldest byte ends up MSB.
  assign data_sh_d = DATA_WIDTH'({data_sh_q, i_rx_data});
  assign last_byte = (byte_cnt_q == BCW'(NBYTES - 1));

  // Idle timer only runs mid-frame and restarts on every received byte.
  pc_interface_timeout #(.MAX(TIMEOUT_CYCLES)) u_tmo (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_clr    (i_rx_valid || (state_q == PC_IF_IDLE)),
    .i_en     (state_q != PC_IF_IDLE),
    .o_tc     (tmo_tc)
  );

  // Frame FSM with registered strobes; outputs only change on commit/error.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q    <= PC_IF_IDLE;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      byte_cnt_q <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
`ifdef PC_INTERFACE_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      wr_q  <= 1'b0;
      err_q <= 1'b0;
      if (tmo_tc) begin
        // tmo_tc is already masked by i_rx_valid, so a byte always wins.
        state_q   <= PC_IF_IDLE;
        err_q     <= 1'b1;
        code_q    <= PC_IF_ERR_TIMEOUT;
        addr_sh_q <= '0;
        data_sh_q <= '0;
      end else if (i_rx_valid) begin
        case (state_q)
          PC_IF_IDLE: begin
            if (i_rx_data == PC_IF_SYNC_BYTE) state_q <= PC_IF_ADDR;
          end
          PC_IF_ADDR: begin
            if (!pc_if_addr_ok(i_rx_data, ADDR_WIDTH)) begin
              state_q <= PC_IF_IDLE;
              err_q   <= 1'b1;
              code_q  <= PC_IF_ERR_ADDR;
            end else begin
              addr_sh_q  <= i_rx_data[ADDR_WIDTH-1:0];
              byte_cnt_q <= '0;
              state_q    <= PC_IF_DATA;
`ifdef PC_INTERFACE_CHECKSUM_EN
              chk_q      <= i_rx_data;
`endif
            end
          end
          PC_IF_DATA: begin
            data_sh_q  <= data_sh_d;
            byte_cnt_q <= byte_cnt_q + BCW'(1);
`ifdef PC_INTERFACE_CHECKSUM_EN
            chk_q      <= chk_q ^ i_rx_data;
            if (last_byte) state_q <= PC_IF_CHK;
`else
            if (last_byte) begin
              addr_q  <= addr_sh_q;
              data_q  <= data_sh_d;
              wr_q    <= 1'b1;
              state_q <= PC_IF_IDLE;
            end
`endif
          end
`ifdef PC_INTERFACE_CHECKSUM_EN
          PC_IF_CHK: begin
            state_q <= PC_IF_IDLE;
            if (i_rx_data == chk_q) begin
              addr_q <= addr_sh_q;
              data_q <= data_sh_q;
              wr_q   <= 1'b1;
            end else begin
              err_q  <= 1'b1;
              code_q <= PC_IF_ERR_CHK;
            end
          end
`endif
          default: state_q <= PC_IF_IDLE;
        endcase
      end
    end
  end

  assign o_wr       = wr_q;
  assign o_err      = err_q;
  assign o_err_code = code_q;
  assign o_addr     = addr_q;
  assign o_data     = data_q;
  assign o_busy     = (state_q != PC_IF_IDLE);

endmodule

// File: tb/tb_pc_interface_cmd_decoder.sv
// tb_pc_interface_cmd_decoder: directed test-plan frames plus randomized
// frames, checked every cycle against a byte-queue frame model.
module tb_pc_interface_cmd_decoder;

  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int TMO = 16;
  localparam int NB  = DW / 8;
`ifdef PC_INTERFACE_CHECKSUM_EN
  localparam int FL  = NB + 2;  // bytes after sync
  localparam bit HAS_CHK = 1'b1;
`else
  localparam int FL  = NB + 1;
  localparam bit HAS_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          o_wr, o_busy, o_err;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic [1:0]    o_err_code;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_interface_cmd_decoder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_wr(o_wr), .o_addr(o_addr), .o_data(o_data), .o_busy(o_busy),
    .o_err(o_err), .o_err_code(o_err_code)
  );

  // ---------------- reference model: queue of bytes since sync ----------------
  bit            in_frame = 0;
  logic [7:0]    fq[$];
  int            idle = 0;
  logic          m_wr = 0, m_err = 0;
  logic [1:0]    m_code = 0;
  logic [AW-1:0] m_addr = 0;
  logic [DW-1:0] m_data = 0;
  logic [7:0]    mx, tmp;
  logic [DW-1:0] md;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame = 0; fq.delete(); idle = 0;
      m_wr = 0; m_err = 0; m_code = 0; m_addr = 0; m_data = 0;
    end else begin
      m_wr = 0; m_err = 0;
      if (in_frame) begin
        if (rx_valid) begin
          fq.push_back(rx_data);
          idle = 0;
          if (fq.size() == 1 && rx_data >= (8'd1 << AW)) begin
            m_err = 1; m_code = 2'd1; in_frame = 0;
          end else if (fq.size() == FL) begin
            mx = fq[0]; md = '0;
            for (int i = 1; i <= NB; i++) begin
              md = (md << 8) | DW'(fq[i]);
              mx = mx ^ fq[i];
            end
            in_frame = 0;
            if (HAS_CHK && fq[FL-1] != mx) begin
              m_err = 1; m_code = 2'd2;
            end else begin
              tmp = fq[0];
              m_wr = 1; m_addr = tmp[AW-1:0]; m_data = md;
            end
          end
        end else begin
          idle++;
          if (idle == TMO) begin
            m_err = 1; m_code = 2'd3; in_frame = 0;
          end
        end
      end else if (rx_valid && rx_data == 8'hA5) begin
        in_frame = 1; fq.delete(); idle = 0;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    tests++;
    if (o_wr !== m_wr || o_err !== m_err || o_busy !== in_frame ||
        o_addr !== m_addr || o_data !== m_data || o_err_code !== m_code) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t dut wr=%b err=%b busy=%b a=%h d=%h c=%b, need wr=%b err=%b busy=%b a=%h d=%h c=%b",
               $time, o_wr, o_err, o_busy, o_addr, o_data, o_err_code,
               m_wr, m_err, in_frame, m_addr, m_data, m_code);
    end
  end

  // Strobe log used by the literal test-plan checks.
  int            wr_cnt = 0, err_cnt = 0;
  logic [1:0]    last_code = 0;
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  always @(negedge clk) begin
    if (o_wr)  begin wr_cnt++; wa.push_back(o_addr); wd.push_back(o_data); end
    if (o_err) begin err_cnt++; last_code = o_err_code; end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b, input int gap);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    repeat (gap) begin @(negedge clk); rx_valid = 1'b0; end
  endtask

  task automatic idle_n(input int n);
    repeat (n) begin @(negedge clk); rx_valid = 1'b0; end
  endtask

  task automatic frame(input logic [7:0] a, input logic [DW-1:0] d, input logic [7:0] cflip, input int gap);
    logic [7:0] x;
    logic [7:0] b;
    x = a;
    put(8'hA5, gap); put(a, gap);
    for (int i = NB - 1; i >= 0; i--) begin
      b = d[i*8 +: 8]; x ^= b; put(b, gap);
    end
    if (HAS_CHK) put(x ^ cflip, gap);
  endtask

  int w0, e0, kind, g, n;
  logic [7:0] ab;

  initial begin
    // Reset state
    #3; check("reset_outputs", {o_wr, o_err, o_busy, 5'b0, o_addr, o_data, o_err_code}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    idle_n(2);

    // 1: valid frame
    frame(8'h03, 16'h1234, 8'h00, 0); idle_n(3);
    check("t1_wr_cnt", wr_cnt, 1);
    check("t1_addr", wa[wa.size()-1], 3);
    check("t1_data", wd[wd.size()-1], 16'h1234);
    check("t1_no_err", err_cnt, 0);

    // 2: bad checksum
    if (HAS_CHK) begin
      frame(8'h03, 16'h1234, 8'h25, 0); idle_n(3);
      check("t2_err_cnt", err_cnt, 1);
      check("t2_code", last_code, 2'b10);
      check("t2_no_wr", wr_cnt, 1);
      check("t2_hold", {o_addr, o_data}, {3'd3, 16'h1234});
    end

    // 3: bad address, trailing bytes ignored
    w0 = wr_cnt; e0 = err_cnt;
    put(8'hA5, 0); put(8'h08, 0); put(8'h12, 0); put(8'h34, 0); idle_n(3);
    check("t3_err", err_cnt - e0, 1);
    check("t3_code", last_code, 2'b01);
    check("t3_no_wr", wr_cnt - w0, 0);
    check("t3_idle", o_busy, 0);

    // 4: timeout then recovery
    e0 = err_cnt;
    put(8'hA5, 0); put(8'h03, 0); put(8'h12, 0); idle_n(TMO + 4);
    check("t4_err", err_cnt - e0, 1);
    check("t4_code", last_code, 2'b11);
    check("t4_busy", o_busy, 0);
    frame(8'h05, 16'h0007, 8'h00, 0); idle_n(3);
    check("t4_addr", wa[wa.size()-1], 5);
    check("t4_data", wd[wd.size()-1], 16'h0007);

    // 5: garbage then back-to-back frames
    w0 = wr_cnt;
    put(8'h00, 0); put(8'hFF, 0);
    frame(8'h01, 16'hABCD, 8'h00, 0);
    frame(8'h02, 16'h0001, 8'h00, 0); idle_n(3);
    check("t5_wr_cnt", wr_cnt - w0, 2);
    check("t5_first", {wa[wa.size()-2], wd[wd.size()-2]}, {3'd1, 16'hABCD});
    check("t5_second", {wa[wa.size()-1], wd[wd.size()-1]}, {3'd2, 16'h0001});

    // 6: reset mid-frame
    w0 = wr_cnt;
    put(8'hA5, 0); put(8'h03, 0); put(8'h12, 0);
    #2 rst_n = 1'b0; rx_valid = 1'b0;
    #1 check("t6_reset_outputs", {o_wr, o_err, o_busy, 5'b0, o_addr, o_data, o_err_code}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    put(8'h34, 0); put(8'h25, 0); idle_n(3);
    check("t6_no_wr", wr_cnt - w0, 0);

    // Randomized frames: good, bad addr, bad checksum, garbage, truncated, near-timeout gaps
    for (int it = 0; it < 400; it++) begin
      kind = $urandom_range(0, 9);
      g = $urandom_range(0, 2);
      case (kind)
        0, 1, 2, 3: frame(8'($urandom_range(0, 7)), DW'($urandom), 8'h00, g);
        4: frame(8'($urandom_range(8, 255)), DW'($urandom), 8'h00, g);
        5: frame(8'($urandom_range(0, 7)), DW'($urandom), 8'($urandom_range(1, 255)), g);
        6: begin
          n = $urandom_range(1, 4);
          repeat (n) put(8'($urandom), g);
        end
        7: begin
          n = $urandom_range(0, FL - 1);
          put(8'hA5, g);
          repeat (n) put(8'($urandom_range(0, 7)), g);
          idle_n($urandom_range(TMO - 2, TMO + 3));
        end
        default: begin
          ab = 8'($urandom_range(0, 7));
          put(8'hA5, $urandom_range(TMO - 2, TMO + 1));
          put(ab, $urandom_range(TMO - 1, TMO));
          repeat (NB + 1) put(8'($urandom), $urandom_range(0, TMO));
        end
      endcase
      idle_n($urandom_range(0, 2));
    end
    idle_n(TMO + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_interface_cmd_decoder.md
# pc_interface_cmd_decoder

Byte-stream command decoder sitting directly upstream of the PC-interface write bank. It consumes bytes from the UART receiver, assembles framed write commands (sync, address, data, optional checksum) and emits a single-cycle write strobe with address and data that drive the write bank's `i_wr`/`i_addr`/`i_data` inputs. It also reports malformed or stalled frames to the status logic.

## Interface
- `DATA_WIDTH`, 16, register data width; multiple of 8, at least 8.
- `ADDR_WIDTH`, 3, register address width; at most 8.
- `TIMEOUT_CYCLES`, 100000, maximum idle clocks between bytes inside a frame; at least 2.
- `i_clk`  in  1  system clock; single clock domain.
- `i_arst_n`  in  1  asynchronous, active-low reset.
- `i_rx_valid`  in  1  one-cycle strobe; `i_rx_data` is valid this cycle.
- `i_rx_data`  in  8  received byte.
- `o_wr`  out  1  one-cycle write strobe to the write bank.
- `o_addr`  out  ADDR_WIDTH  write address; stable until the next `o_wr`.
- `o_data`  out  DATA_WIDTH  write data; stable until the next `o_wr`.
- `o_busy`  out  1  high while a frame is in progress (state not IDLE).
- `o_err`  out  1  one-cycle error strobe.
- `o_err_code`  out  2  01 = address out of range, 10 = checksum mismatch, 11 = timeout. Held until the next `o_err`.

## Operation
- Frame format, in byte order:
  - sync 0xA5
  - address byte
  - DATA_WIDTH/8 data bytes, MSB first
  - checksum byte, only when the checksum feature is compiled in
- FSM states: IDLE, ADDR, DATA, CHK.
- IDLE:
  - 0xA5 moves to ADDR.
  - Any other byte is silently ignored, with no error.
- ADDR:
  - Bits [7:ADDR_WIDTH] nonzero: pulse `o_err` with code 01 and return to IDLE.
  - Otherwise latch the address into a shadow register, clear the byte counter and move to DATA.
- DATA:
  - Shift each byte into a shadow data register, MSB first.
  - After byte DATA_WIDTH/8, move to CHK (checksum feature in) or commit (feature out).
- CHK: the byte must equal the XOR of the address byte and all data bytes.
  - Match: commit.
  - Mismatch: pulse `o_err` with code 10 and return to IDLE.
- Commit:
  - Copy the shadow registers to `o_addr`/`o_data`.
  - Pulse `o_wr` and return to IDLE.
- No mid-frame resync: 0xA5 inside a frame is treated as payload.
- Timeout: a counter clears on every `i_rx_valid` and counts while not IDLE. When it reaches TIMEOUT_CYCLES: pulse `o_err` with code 11, return to IDLE, and discard the shadow registers.
- A failed frame never changes `o_addr`/`o_data`.

## Timing
- Reset values:
  - state IDLE
  - `o_wr`, `o_err`, `o_busy` = 0
  - `o_addr`, `o_data`, `o_err_code` = 0
  - counters 0
- Commit latency: `o_wr`, `o_addr` and `o_data` update on the clock edge following the cycle in which the final byte is sampled. `o_wr` is high for exactly 1 cycle.
- Error latency: `o_err` and `o_err_code` update on the edge after the offending byte, or on the edge where the timeout count is reached.
- `o_busy` rises the cycle after sync is sampled and falls in the same cycle `o_wr` or `o_err` is high.
- Back-to-back bytes (`i_rx_valid` on consecutive cycles) are fully supported. A new sync byte on the cycle where `o_wr` is high is accepted.
- If the timeout count and a valid byte coincide, the byte wins and the counter clears.
- Reset mid-frame aborts the frame with no strobe. Write-bank contents are unaffected by the decoder.

## Configuration
- `PC_INTERFACE_CHECKSUM_EN` defined:
  - CHK state and the XOR accumulator are present.
  - Frame length is 3 + DATA_WIDTH/8 bytes.
  - Error code 10 is possible.
- Not defined:
  - Commit occurs directly after the last data byte.
  - Frame length is 2 + DATA_WIDTH/8 bytes.
  - Code 10 is never produced.

## Structure
- Shared package `pc_interface_pkg` holds:
  - `PC_IF_SYNC_BYTE` = 8'hA5
  - the FSM state encoding
  - error codes `PC_IF_ERR_ADDR`, `PC_IF_ERR_CHK`, `PC_IF_ERR_TIMEOUT`
- One sub-module, `pc_interface_timeout`: a clearable/enable-able counter with a terminal-count pulse, reused by other PC-interface stages.

## Test plan
All scenarios use DATA_WIDTH=16, ADDR_WIDTH=3, TIMEOUT_CYCLES=16, checksum feature in, unless stated.

1. Valid frame: bytes A5 03 12 34 25 -> one `o_wr` pulse with `o_addr`=3 and `o_data`=0x1234, no `o_err`.
2. Bad checksum: A5 03 12 34 00 -> `o_err`=1 with `o_err_code`=10, no `o_wr`, `o_addr`/`o_data` keep their previous values.
3. Bad address: A5 08 -> `o_err` with code 01 one cycle after byte 08. Following bytes 12 34 are ignored until the next A5.
4. Timeout: A5 03 12, then 16 idle cycles -> `o_err` with code 11 and `o_busy`=0. A following A5 05 00 07 02 writes address 5 with data 0x0007.
5. Leading garbage and back-to-back frames: 00 FF A5 01 AB CD 67, then A5 02 00 01 03 immediately -> two `o_wr` pulses: (1, 0xABCD), then (2, 0x0001).
6. Reset mid-frame: A5 03 12, assert `i_arst_n`=0 -> all outputs 0. After release, 34 25 produces no `o_wr`.
